mul6_seq_ctrl: RTL and testbench
================================

# mul6_seq_ctrl

Sequencing controller for the 6x6 multiplier tile. Accepts two 6-bit operands as consecutive beats on an 8-bit valid/ready input bus, runs a 6-cycle shift-add multiply on one shared adder, and returns the 12-bit product as two byte beats on a valid/ready output bus. It sits between the tile's pin-level I/O wrapper and the multiplier datapath, and owns all sequencing and flow control.

## Interface
- `W`, default 6: operand width. The product is 2W bits. The counter width is sized to hold W.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  8: operand beat. Bits [W-1:0] are the operand; the use of [7:W] is set under Configuration.
- `in_valid`  in  1: source presents `in_data`.
- `in_ready`  out  1: controller accepts a beat; a transfer occurs when `in_valid && in_ready` at an edge.
- `out_data`  out  8: result beat.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: sink accepts a beat; a transfer occurs when `out_valid && out_ready` at an edge.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- States and transitions:
  - IDLE → LOAD_B on an input transfer. The transfer captures A = `in_data[W-1:0]`.
  - LOAD_B → MUL on an input transfer. The transfer captures B, clears the accumulator, and clears the counter.
  - MUL → OUT_LO after exactly W cycles.
  - OUT_LO → OUT_HI on an output transfer.
  - OUT_HI → IDLE on an output transfer.
- `in_ready` = 1 only in IDLE and LOAD_B. It is decoded combinationally from the state.
- MUL step i (i = 0..W-1): if B[i] = 1, then acc ← acc + (A << i). The counter increments each step. The accumulator is 2W bits, with no overflow (max 63*63 = 3969).
- Only one adder is used; no combinational array is instantiated in this block.
- OUT_LO: `out_data` = prod[7:0].
- OUT_HI: `out_data` = {4'b0, prod[11:8]} (non-ACC build).
- `out_valid` = 1 only in OUT_LO and OUT_HI. `out_data` = 8'h00 whenever `out_valid` = 0.
- While `out_valid` is high and `out_ready` is low, `out_data` is held stable and the state does not advance.
- `in_valid` is ignored in MUL, OUT_LO and OUT_HI. No beat is consumed.

## Timing
- Reset: state = IDLE, A = B = acc = counter = 0, `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `busy` = 0. All take effect on the first edge with `rst` high.
- `rst` has priority over every other event in any state. An operation interrupted by reset is discarded, and no partial result is ever emitted.
- Latency: B is accepted at edge E. The state is MUL for cycles E+1..E+6. `out_valid` rises after edge E+6.
- Minimum operation period, with `in_valid`/`out_ready` held high: 10 cycles (A, B, 6 MUL, 2 OUT).
- Back-to-back: an A beat may be accepted on the cycle immediately after the OUT_HI transfer. There is no bubble beyond the IDLE state itself.
- `in_ready` and `out_valid` do not depend combinationally on `in_valid` or `out_ready`.

## Configuration
- Macro `MUL6_ACC_EN`.
- Defined:
  - Adds a 16-bit running total: total ← total + product on the MUL → OUT_LO edge, wrapping mod 2^16.
  - OUT_LO carries total[7:0]; OUT_HI carries total[15:8].
  - An A beat with `in_data[7]` = 1 clears the total before this operation's product is added.
  - `rst` clears the total.
- Undefined:
  - No total register exists.
  - `in_data[7:W]` is ignored on both beats.
  - Output beats carry the product only, as defined under Operation.

## Test plan
- Reset: hold `rst` for 2 cycles with `in_valid` = 1. Required: `in_ready` = 1, `out_valid` = 0, `out_data` = 0x00, `busy` = 0, and no beat consumed.
- Max operands: A = 63, B = 63. Required: `out_valid` rises exactly 6 cycles after the B transfer; beats are 0x81 then 0x0F (3969).
- Operand edge cases:
  - A = 0, B = 45 → 0x00, 0x00.
  - A = 5, B = 7 with `in_data[7:6]` = 2'b11 → 0x23, 0x00 (non-ACC build).
- Backpressure: `out_ready` = 0 for 10 cycles during OUT_LO of 63x63. Required: `out_data` is held at 0x81, `in_ready` = 0, `busy` = 1, and `in_valid` pulses are ignored. Then release → 0x0F → IDLE.
- Reset mid-operation: assert `rst` on the 3rd MUL cycle. Required: next cycle IDLE, `out_valid` = 0. Then 2x3 → 0x06, 0x00.
- `MUL6_ACC_EN`: run 63x63 with `in_data[7]` = 1 on A, then 63x63 with `in_data[7]` = 0. Required: beats 0x81, 0x0F, then 0x02, 0x1F (7938).

Source files
------------

// File: rtl/mul6_seq_ctrl.sv
// mul6_seq_ctrl: sequencing controller for the 6x6 multiplier tile.
// Takes operands A then B as byte beats on a valid/ready input bus, runs a
// W-step shift-add multiply on a single shared adder, and returns the result
// as two byte beats (low, then high) on a valid/ready output bus.
// Optional feature macro: MUL6_ACC_EN (16-bit running total of all products;
// an A beat with in_data[7] set clears the total).
module mul6_seq_ctrl #(
   parameter int W = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_B,
      MUL,
      OUT_LO,
      OUT_HI
   } state_t;

   state_t state;
   state_t state_next;

   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] acc;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] addend;
   logic [2*W-1:0] sum;
   logic           last_step;
   logic [15:0]    result;
   logic           unused_in_bits;

`ifdef MUL6_ACC_EN
   logic [15:0]    total;
`endif

   // Operand high bits are only meaningful as the clear flag in the ACC build.
   assign unused_in_bits = ^in_data[7:W];

   // The one shared adder: add A shifted by the step index when B's bit is set.
   always_comb begin
      addend    = '0;
      if (b[cnt]) begin
         addend = {{W{1'b0}}, a} << cnt;
      end
      sum       = acc + addend;
      last_step = (cnt == CW'(W - 1));
   end

   // State register; reset wins over every transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: input transfers in IDLE/LOAD_B, W steps in MUL,
   // output transfers in OUT_LO/OUT_HI.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = LOAD_B;
         LOAD_B:  if (in_valid)  state_next = MUL;
         MUL:     if (last_step) state_next = OUT_LO;
         OUT_LO:  if (out_ready) state_next = OUT_HI;
         OUT_HI:  if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture operands, step the accumulator, maintain the total.
   always_ff @(posedge clk) begin
      if (rst) begin
         a   <= '0;
         b   <= '0;
         acc <= '0;
         cnt <= '0;
`ifdef MUL6_ACC_EN
         total <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a <= in_data[W-1:0];
`ifdef MUL6_ACC_EN
                  if (in_data[7]) begin
                     total <= '0;
                  end
`endif
               end
            end
            LOAD_B: begin
               if (in_valid) begin
                  b   <= in_data[W-1:0];
                  acc <= '0;
                  cnt <= '0;
               end
            end
            MUL: begin
               acc <= sum;
               cnt <= cnt + 1'b1;
`ifdef MUL6_ACC_EN
               if (last_step) begin
                  total <= total + 16'(sum);
               end
`endif
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs are pure state decodes so they never depend on in_valid/out_ready.
   always_comb begin
`ifdef MUL6_ACC_EN
      result = total;
`else
      result = 16'(acc);
`endif
      in_ready  = (state == IDLE) || (state == LOAD_B);
      out_valid = (state == OUT_LO) || (state == OUT_HI);
      busy      = (state != IDLE);
      out_data  = 8'h00;
      if (state == OUT_LO) begin
         out_data = result[7:0];
      end else if (state == OUT_HI) begin
         out_data = result[15:8];
      end
   end

endmodule

// File: tb/tb_mul6_seq_ctrl.sv
// tb_mul6_seq_ctrl: randomized self-checking bench for mul6_seq_ctrl.
// The reference model works on whole operations: expected result = A*B
// (or a running 16-bit total when MUL6_ACC_EN is defined).
module tb_mul6_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   int compared   = 0;
   int mismatched = 0;
   int model_total = 0;

   mul6_seq_ctrl #(.W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference model: result of one whole operation, split into two beats.
   task automatic model_op(input logic [7:0] a_byte, input logic [7:0] b_byte,
                           output logic [7:0] lo, output logic [7:0] hi);
      int prod;
      int res;
      prod = int'(a_byte[5:0]) * int'(b_byte[5:0]);
`ifdef MUL6_ACC_EN
      if (a_byte[7]) model_total = 0;
      model_total = (model_total + prod) % 65536;
      res = model_total;
`else
      res = prod;
`endif
      lo = 8'(res % 256);
      hi = 8'(res / 256);
   endtask

   // Drive one input beat (called and returning at a falling edge).
   task automatic send_beat(input logic [7:0] d, output bit ok);
      int n;
      n = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   // Accept one output beat after a random backpressure delay.
   task automatic recv_beat(output logic [7:0] d, output bit ok);
      int n;
      n = 0;
      out_ready = 1'b0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = out_valid;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = out_data;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // One complete operation with random idle gaps between beats.
   task automatic run_op(input logic [7:0] a_byte, input logic [7:0] b_byte,
                         output logic [7:0] lo, output logic [7:0] hi, output bit ok);
      bit ok1, ok2, ok3, ok4;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(a_byte, ok1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(b_byte, ok2);
      recv_beat(lo, ok3);
      recv_beat(hi, ok4);
      ok = ok1 && ok2 && ok3 && ok4;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h2A;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      compared++;
      if ({in_ready, out_valid, out_data, busy} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b data=%h busy=%b, want 1 0 00 0",
                  in_ready, out_valid, out_data, busy);
      end
      @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_no_beat: busy=%b, want 0", busy);
      end
      model_total = 0;
   endtask

   task automatic test_max_operands();
      bit ok1, ok2, ok3, ok4;
      int n;
      logic [7:0] elo, ehi, lo, hi;
      model_op(8'h3F, 8'h3F, elo, ehi);
      send_beat(8'h3F, ok1);
      send_beat(8'h3F, ok2);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (n !== 6 || !ok1 || !ok2) begin
         mismatched++;
         $display("[TB] FAIL max_latency: got %0d cycles, want 6", n);
      end
      recv_beat(lo, ok3);
      recv_beat(hi, ok4);
      compared++;
      if ({lo, hi} !== {elo, ehi} || !ok3 || !ok4) begin
         mismatched++;
         $display("[TB] FAIL max_beats: got %h %h, want %h %h", lo, hi, elo, ehi);
      end
   endtask

   task automatic test_edge_cases();
      logic [7:0] as[3] = '{8'h00, 8'hC5, 8'h3F};
      logic [7:0] bs[3] = '{8'h2D, 8'hC7, 8'h00};
      logic [7:0] elo, ehi, lo, hi;
      bit ok;
      for (int i = 0; i < 3; i++) begin
         model_op(as[i], bs[i], elo, ehi);
         run_op(as[i], bs[i], lo, hi, ok);
         compared++;
         if ({lo, hi} !== {elo, ehi} || !ok) begin
            mismatched++;
            $display("[TB] FAIL edge_%0d: got %h %h, want %h %h", i, lo, hi, elo, ehi);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, ok3, ok4;
      int n;
      int bad;
      logic [7:0] elo, ehi, lo, hi;
      model_op(8'h3F, 8'h3F, elo, ehi);
      send_beat(8'h3F, ok1);
      send_beat(8'h3F, ok2);
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom_range(0, 255));
         if (out_data !== elo || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
            bad++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      compared++;
      if (bad !== 0 || !ok1 || !ok2) begin
         mismatched++;
         $display("[TB] FAIL backpressure_hold: %0d bad cycles (data=%h), want 0 (data=%h)",
                  bad, out_data, elo);
      end
      recv_beat(lo, ok3);
      recv_beat(hi, ok4);
      compared++;
      if ({lo, hi} !== {elo, ehi} || !ok3 || !ok4) begin
         mismatched++;
         $display("[TB] FAIL backpressure_beats: got %h %h, want %h %h", lo, hi, elo, ehi);
      end
      compared++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL backpressure_idle: busy=%b rdy=%b, want 0 1", busy, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      bit ok1, ok2, ok;
      logic [7:0] elo, ehi, lo, hi;
      send_beat(8'($urandom_range(1, 63)), ok1);
      send_beat(8'($urandom_range(1, 63)), ok2);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_total = 0;
      compared++;
      if ({busy, out_valid, in_ready, out_data} !== {1'b0, 1'b0, 1'b1, 8'h00} || !ok1 || !ok2) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_state: got busy=%b vld=%b rdy=%b data=%h, want 0 0 1 00",
                  busy, out_valid, in_ready, out_data);
      end
      model_op(8'h02, 8'h03, elo, ehi);
      run_op(8'h02, 8'h03, lo, hi, ok);
      compared++;
      if ({lo, hi} !== {elo, ehi} || !ok) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_after: got %h %h, want %h %h", lo, hi, elo, ehi);
      end
   endtask

   task automatic test_random();
      logic [7:0] a_byte, b_byte, elo, ehi, lo, hi;
      bit ok;
      for (int i = 0; i < 20; i++) begin
         a_byte = 8'($urandom_range(0, 255));
         b_byte = 8'($urandom_range(0, 255));
         model_op(a_byte, b_byte, elo, ehi);
         run_op(a_byte, b_byte, lo, hi, ok);
         compared++;
         if ({lo, hi} !== {elo, ehi} || !ok) begin
            mismatched++;
            $display("[TB] FAIL random_%0d (%h x %h): got %h %h, want %h %h",
                     i, a_byte, b_byte, lo, hi, elo, ehi);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] beats[6];
      logic [7:0] expect_q[6];
      logic [7:0] got[6];
      int a_cyc[3];
      int idx, nout, cyc;
      for (int i = 0; i < 6; i++) beats[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 3; i++) model_op(beats[2*i], beats[2*i+1], expect_q[2*i], expect_q[2*i+1]);
      for (int i = 0; i < 6; i++) got[i] = 8'hXX;
      for (int i = 0; i < 3; i++) a_cyc[i] = -100;
      idx = 0;
      nout = 0;
      cyc = 0;
      out_ready = 1'b1;
      while ((idx < 6 || nout < 6) && cyc < 80) begin
         if (out_valid && nout < 6) begin
            got[nout] = out_data;
            nout++;
         end
         if (idx < 6) begin
            in_valid = 1'b1;
            in_data  = beats[idx];
            if (in_ready) begin
               if (idx % 2 == 0) a_cyc[idx/2] = cyc;
               idx++;
            end
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      compared++;
      if (a_cyc[1] - a_cyc[0] !== 10 || a_cyc[2] - a_cyc[1] !== 10) begin
         mismatched++;
         $display("[TB] FAIL b2b_period: got %0d %0d, want 10 10",
                  a_cyc[1] - a_cyc[0], a_cyc[2] - a_cyc[1]);
      end
      for (int i = 0; i < 6; i++) begin
         compared++;
         if (got[i] !== expect_q[i]) begin
            mismatched++;
            $display("[TB] FAIL b2b_beat_%0d: got %h, want %h", i, got[i], expect_q[i]);
         end
      end
   endtask

`ifdef MUL6_ACC_EN
   task automatic test_accumulate();
      logic [7:0] lo, hi;
      bit ok;
      run_op(8'hBF, 8'h3F, lo, hi, ok);
      model_total = 3969;
      compared++;
      if ({lo, hi} !== {8'h81, 8'h0F} || !ok) begin
         mismatched++;
         $display("[TB] FAIL acc_first: got %h %h, want 81 0f", lo, hi);
      end
      run_op(8'h3F, 8'h3F, lo, hi, ok);
      model_total = 7938;
      compared++;
      if ({lo, hi} !== {8'h02, 8'h1F} || !ok) begin
         mismatched++;
         $display("[TB] FAIL acc_second: got %h %h, want 02 1f", lo, hi);
      end
   endtask
`endif

   // Run every scenario in order, then report.
   initial begin
      rst = 1'b1;
      in_data = 8'h00;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_max_operands();
      test_edge_cases();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
`ifdef MUL6_ACC_EN
      test_accumulate();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
